// File: rtl/intersection_pkg.sv
// Shared types, light encodings and default timing for the intersection scheduler.
// The pedestrian walk phase exists only when PED_REQUEST_EN is defined.
package intersection_pkg;

    typedef logic [2:0] state_t;
    typedef logic [2:0] light_t;

    localparam state_t AR_NS    = 3'd0;
    localparam state_t NS_G     = 3'd1;
    localparam state_t NS_Y     = 3'd2;
    localparam state_t AR_EW    = 3'd3;
    localparam state_t EW_G     = 3'd4;
    localparam state_t EW_Y     = 3'd5;
    localparam state_t PED_WALK = 3'd6;

    localparam light_t GREEN  = 3'b100;
    localparam light_t YELLOW = 3'b010;
    localparam light_t RED    = 3'b001;

    localparam int DEF_TICK_DIV  = 256;
    localparam int DEF_GREEN_MIN = 5;
    localparam int DEF_GREEN_MAX = 15;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 8;

    function automatic light_t head_light(input state_t s, input state_t g, input state_t y);
        return (s == g) ? GREEN : ((s == y) ? YELLOW : RED);
    endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Detector inputs and light-head outputs of the intersection scheduler.
// master: the scheduler side; slave: the detector/lamp side.
interface intersection_scheduler_if;
    import intersection_pkg::*;

    logic     carNS;
    logic     carEW;
    logic     pedReq;
    light_t   nsLight;
    light_t   ewLight;
    logic     walk;
    logic [3:0] timerDisp;
    state_t   phase;

    modport master (
        input  carNS, carEW, pedReq,
        output nsLight, ewLight, walk, timerDisp, phase
    );

    modport slave (
        output carNS, carEW, pedReq,
        input  nsLight, ewLight, walk, timerDisp, phase
    );

endinterface

// File: rtl/second_tick_gen.sv
// Free-running prescaler: one-cycle tick each time the count wraps TICK_DIV-1 -> 0.
module second_tick_gen #(
    parameter int TICK_DIV = 256
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-actuated two-approach traffic light sequencer with min/max green, yellow and all-red.
// Define PED_REQUEST_EN to add the pedestrian walk phase driven by pedReq.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T
) (
    input  logic quartzClock,
    input  logic reset,
    intersection_scheduler_if.master bus
);

    localparam logic [3:0] T_GMIN = 4'(GREEN_MIN);
    localparam logic [3:0] T_GMAX = 4'(GREEN_MAX);
    localparam logic [3:0] T_YEL  = 4'(YELLOW_T);
    localparam logic [3:0] T_AR   = 4'(ALLRED_T);

    logic       tick;
    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d, timer_dec, elapsed;
    logic       dem_ns_q, dem_ns_d, dem_ew_q, dem_ew_d;
    logic       enter_ns_g, enter_ew_g, ped_dem;

    light_t     ns_light_q, ew_light_q;
    logic [3:0] timer_disp_q;
    state_t     phase_q;

    second_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i   (quartzClock),
        .reset_i (reset),
        .tick_o  (tick)
    );

`ifdef PED_REQUEST_EN
    localparam logic [3:0] T_WALK = 4'(WALK_T);
    logic dem_ped_q, dem_ped_d, ped_to_ew_q, ped_to_ew_d, enter_ped, walk_q;

    assign ped_dem   = dem_ped_q;
    assign dem_ped_d = bus.pedReq | (dem_ped_q & ~enter_ped);
    assign bus.walk  = walk_q;

    always_ff @(posedge quartzClock) begin
        if (reset) begin
            dem_ped_q   <= 1'b0;
            ped_to_ew_q <= 1'b0;
            walk_q      <= 1'b0;
        end else begin
            dem_ped_q   <= dem_ped_d;
            ped_to_ew_q <= ped_to_ew_d;
            walk_q      <= (state_q == PED_WALK);
        end
    end
`else
    logic [4:0] ped_unused;
    assign ped_unused = {bus.pedReq, 4'(WALK_T)};
    assign ped_dem    = 1'b0;
    assign bus.walk   = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        timer_dec = timer_q;
        if (tick && (timer_q != 4'd0)) timer_dec = timer_q - 4'd1;
        elapsed    = T_GMAX - timer_dec;
        state_d    = state_q;
        timer_d    = timer_dec;
        enter_ns_g = 1'b0;
        enter_ew_g = 1'b0;
`ifdef PED_REQUEST_EN
        enter_ped   = 1'b0;
        ped_to_ew_d = ped_to_ew_q;
`endif
        if (tick) begin
            case (state_q)
                AR_NS, AR_EW: if (timer_dec == 4'd0) begin
`ifdef PED_REQUEST_EN
                    if (dem_ped_q) begin
                        state_d     = PED_WALK;
                        timer_d     = T_WALK;
                        enter_ped   = 1'b1;
                        ped_to_ew_d = (state_q == AR_EW);
                    end else
`endif
                    if (state_q == AR_NS) begin
                        state_d    = NS_G;
                        timer_d    = T_GMAX;
                        enter_ns_g = 1'b1;
                    end else begin
                        state_d    = EW_G;
                        timer_d    = T_GMAX;
                        enter_ew_g = 1'b1;
                    end
                end
                // A green with no opposing demand rests at 0 and re-evaluates every tick.
                NS_G: if ((dem_ew_q || ped_dem) && (elapsed >= T_GMIN)) begin
                    state_d = NS_Y;
                    timer_d = T_YEL;
                end
                EW_G: if ((dem_ns_q || ped_dem) && (elapsed >= T_GMIN)) begin
                    state_d = EW_Y;
                    timer_d = T_YEL;
                end
                NS_Y: if (timer_dec == 4'd0) begin
                    state_d = AR_EW;
                    timer_d = T_AR;
                end
                EW_Y: if (timer_dec == 4'd0) begin
                    state_d = AR_NS;
                    timer_d = T_AR;
                end
`ifdef PED_REQUEST_EN
                PED_WALK: if (timer_dec == 4'd0) begin
                    timer_d = T_GMAX;
                    if (ped_to_ew_q) begin
                        state_d    = EW_G;
                        enter_ew_g = 1'b1;
                    end else begin
                        state_d    = NS_G;
                        enter_ns_g = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = AR_NS;
                    timer_d = T_AR;
                end
            endcase
        end
        // Set wins over clear so a car arriving on the green-entry cycle is not lost.
        dem_ns_d = bus.carNS | (dem_ns_q & ~enter_ns_g);
        dem_ew_d = bus.carEW | (dem_ew_q & ~enter_ew_g);
    end

    always_ff @(posedge quartzClock) begin
        if (reset) begin
            state_q      <= AR_NS;
            timer_q      <= T_AR;
            dem_ns_q     <= 1'b0;
            dem_ew_q     <= 1'b0;
            ns_light_q   <= RED;
            ew_light_q   <= RED;
            timer_disp_q <= T_AR;
            phase_q      <= AR_NS;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dem_ns_q     <= dem_ns_d;
            dem_ew_q     <= dem_ew_d;
            ns_light_q   <= head_light(state_q, NS_G, NS_Y);
            ew_light_q   <= head_light(state_q, EW_G, EW_Y);
            timer_disp_q <= timer_q;
            phase_q      <= state_q;
        end
    end

    assign bus.nsLight   = ns_light_q;
    assign bus.ewLight   = ew_light_q;
    assign bus.timerDisp = timer_disp_q;
    assign bus.phase     = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with TICK_DIV = 4 (one tick = 4 cycles).
// The pedestrian scenario switches on PED_REQUEST_EN.
module tb_intersection_scheduler;
    import intersection_pkg::*;

    localparam int TD = 4;

    logic quartzClock = 1'b0;
    logic reset       = 1'b1;
    int   cyc         = 0;
    int   n_checks    = 0;
    int   n_errors    = 0;

    intersection_scheduler_if bus ();

    intersection_scheduler #(.TICK_DIV(TD)) dut (
        .quartzClock (quartzClock),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 quartzClock = ~quartzClock;
    always @(posedge quartzClock) cyc <= cyc + 1;

    // Continuous-demand cycle starting from NS_G: next phase, cycles since previous, heads, display.
    state_t seq_ph   [6] = '{NS_Y, AR_EW, EW_G, EW_Y, AR_NS, NS_G};
    int     seq_dt   [6] = '{5*TD, 3*TD, 1*TD, 5*TD, 3*TD, 1*TD};
    light_t seq_ns   [6] = '{YELLOW, RED, RED, RED, RED, GREEN};
    light_t seq_ew   [6] = '{RED, RED, GREEN, YELLOW, RED, RED};
    int     seq_disp [6] = '{3, 1, 15, 3, 1, 15};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge quartzClock);
        #1;
    endtask

    task automatic wait_phase(input state_t p, input string tag, output int stamp);
        int n = 0;
        while (bus.phase !== p && n < 200) begin
            step(1);
            n++;
        end
        check({tag, " reached"}, bus.phase, p);
        stamp = cyc;
    endtask

    initial begin
        int t0, t1, tr;
        bus.carNS  = 1'b0;
        bus.carEW  = 1'b0;
        bus.pedReq = 1'b0;

        // Reset held 3 cycles
        step(3);
        check("rst nsLight", bus.nsLight, RED);
        check("rst ewLight", bus.ewLight, RED);
        check("rst timerDisp", bus.timerDisp, 1);
        check("rst phase", bus.phase, AR_NS);
        check("rst walk", bus.walk, 0);
        reset = 1'b0;
        tr = cyc;
        wait_phase(NS_G, "first NS_G", t0);
        check("first tick latency", t0 - tr, TD + 1);
        check("first NS_G timerDisp", bus.timerDisp, 15);
        check("first NS_G nsLight", bus.nsLight, GREEN);

        // No demand: NS_G rests for 100 ticks
        for (int i = 0; i < 100; i++) begin
            step(TD);
            check("rest ewLight", bus.ewLight, RED);
        end
        check("rest phase", bus.phase, NS_G);
        check("rest timerDisp", bus.timerDisp, 0);

        // EW car pulse one tick into a fresh NS_G
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        wait_phase(NS_G, "fresh NS_G", t0);
        step(TD - 1);
        bus.carEW = 1'b1;
        step(1);
        bus.carEW = 1'b0;
        wait_phase(NS_Y, "pulse NS_Y", t1);
        check("pulse green len", t1 - t0, 5 * TD);
        check("pulse NS_Y nsLight", bus.nsLight, YELLOW);
        check("pulse NS_Y timerDisp", bus.timerDisp, 3);
        wait_phase(AR_EW, "pulse AR_EW", t0);
        check("pulse yellow len", t0 - t1, 3 * TD);
        check("pulse AR_EW nsLight", bus.nsLight, RED);
        check("pulse AR_EW ewLight", bus.ewLight, RED);
        wait_phase(EW_G, "pulse EW_G", t0);
        check("pulse Y to EW_G", t0 - t1, 16);
        check("pulse EW_G ewLight", bus.ewLight, GREEN);
        check("pulse EW_G nsLight", bus.nsLight, RED);

        // Continuous demand on both approaches
        bus.carNS = 1'b1;
        bus.carEW = 1'b1;
        wait_phase(NS_G, "cont start", t0);
        for (int k = 0; k < 12; k++) begin
            wait_phase(seq_ph[k % 6], "cont phase", t1);
            check("cont duration", t1 - t0, seq_dt[k % 6]);
            check("cont nsLight", bus.nsLight, seq_ns[k % 6]);
            check("cont ewLight", bus.ewLight, seq_ew[k % 6]);
            check("cont timerDisp", bus.timerDisp, seq_disp[k % 6]);
            t0 = t1;
        end

        // Reset in the middle of NS_Y clears state, outputs and demand latches
        wait_phase(NS_Y, "pre-reset NS_Y", t0);
        step(2);
        reset     = 1'b1;
        bus.carNS = 1'b0;
        bus.carEW = 1'b0;
        step(1);
        check("midY rst phase", bus.phase, AR_NS);
        check("midY rst nsLight", bus.nsLight, RED);
        check("midY rst ewLight", bus.ewLight, RED);
        check("midY rst timerDisp", bus.timerDisp, 1);
        reset = 1'b0;
        wait_phase(NS_G, "post-reset NS_G", t0);
        step(30 * TD);
        check("demand cleared phase", bus.phase, NS_G);
        check("demand cleared timerDisp", bus.timerDisp, 0);

        // Pedestrian request during EW_G
        bus.carEW = 1'b1;
        step(1);
        bus.carEW = 1'b0;
        wait_phase(EW_G, "ped EW_G", t0);
        bus.pedReq = 1'b1;
        step(1);
        bus.pedReq = 1'b0;
`ifdef PED_REQUEST_EN
        wait_phase(EW_Y, "ped EW_Y", t1);
        check("ped green len", t1 - t0, 5 * TD);
        wait_phase(AR_NS, "ped AR_NS", t0);
        wait_phase(PED_WALK, "ped PED_WALK", t1);
        check("ped allred len", t1 - t0, TD);
        check("ped walk on", bus.walk, 1);
        check("ped walk timerDisp", bus.timerDisp, 8);
        check("ped walk nsLight", bus.nsLight, RED);
        check("ped walk ewLight", bus.ewLight, RED);
        wait_phase(NS_G, "ped NS_G", t0);
        check("ped walk len", t0 - t1, 8 * TD);
        check("ped walk off", bus.walk, 0);
        step(20 * TD);
        check("ped demand cleared", bus.phase, NS_G);
`else
        for (int i = 0; i < 25; i++) begin
            step(TD);
            check("pedReq ignored walk", bus.walk, 0);
        end
        check("pedReq ignored phase", bus.phase, EW_G);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
